// File: rtl/bus_sequencer_if.sv
// Instruction, interrupt and bus-strobe bundle between a command source and bus_sequencer.
// The transfer-type field is called xfer_type because "type" is a reserved word.
interface bus_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int NUM_IO = 2
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        op;
    logic [1:0]        xfer_type;
    logic [5:0]        count;
    logic [ADDR_W-1:0] source;
    logic [ADDR_W-1:0] destination;
    logic [ADDR_W-1:0] firstempty;
    logic              busybus;
    logic [NUM_IO-1:0] io_ip;
    logic              dma_done;
    logic [ADDR_W-1:0] address;
    logic              mem_rd;
    logic              mem_wr;
    logic [NUM_IO-1:0] io_rd;
    logic [NUM_IO-1:0] io_wr;
    logic [NUM_IO-1:0] io_ack;
    logic              grant;
    logic              err;

    modport master (
        output instr_valid, op, xfer_type, count, source, destination, firstempty,
               busybus, io_ip, dma_done,
        input  instr_ready, address, mem_rd, mem_wr, io_rd, io_wr, io_ack, grant, err
    );

    modport slave (
        input  instr_valid, op, xfer_type, count, source, destination, firstempty,
               busybus, io_ip, dma_done,
        output instr_ready, address, mem_rd, mem_wr, io_rd, io_wr, io_ack, grant, err
    );
endinterface

// File: rtl/bus_sequencer.sv
// Instruction-driven bus sequencer: register/memory/I/O transfers, DMA and ALU bus hand-off, interrupt service.
// Define BUS_SEQ_RR_PRIORITY_EN for round-robin interrupt arbitration (default: fixed, lowest channel wins).
module bus_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int NUM_IO  = 2,
    parameter int IO_BASE = 192,
    parameter int IO_SPAN = 32
) (
    input  logic           clock,
    input  logic           rst_n,
    bus_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, DMA, ALU, IRQ_RD, IRQ_WR} state_t;

    state_t            r_state;
    logic              r_ready;
    logic [ADDR_W-1:0] r_address;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_firstempty;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [NUM_IO-1:0] r_io_rd;
    logic [NUM_IO-1:0] r_io_wr;
    logic [NUM_IO-1:0] r_io_ack;
    logic              r_grant;
    logic              r_err;
    logic              r_two_phase;
    logic              r_wr_io;
    logic [1:0]        r_wr_ch;
`ifdef BUS_SEQ_RR_PRIORITY_EN
    logic [1:0]        r_ptr;
    logic [1:0]        r_irq_ch;
`endif

    logic              w_ready;
    logic              w_accept;
    logic [2:0]        w_src_dec;
    logic [2:0]        w_dst_dec;
    logic              w_src_io;
    logic              w_dst_io;
    logic              w_has_rd;
    logic              w_has_wr;
    logic              w_dma;
    logic              w_bad_op;
    logic              w_bad_ep;
    logic              w_irq_hit;
    logic [1:0]        w_irq_ch;
    logic [ADDR_W-1:0] w_irq_addr;

    // Returns {hit, channel}; a miss means the address belongs to memory.
    function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
        logic [2:0] d;
        int         av;
        av = int'(a);
        d  = 3'b000;
        for (int k = 0; k < NUM_IO; k++)
            if (av >= IO_BASE + k * IO_SPAN && av < IO_BASE + (k + 1) * IO_SPAN)
                d = {1'b1, 2'(k)};
        return d;
    endfunction

    function automatic logic [NUM_IO-1:0] onehot(input logic [1:0] ch);
        logic [NUM_IO-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_IO; k++)
            if (ch == 2'(k)) v[k] = 1'b1;
        return v;
    endfunction

    assign w_ready    = r_ready && !bus.busybus;
    assign w_accept   = bus.instr_valid && w_ready;
    assign w_src_dec  = decode(bus.source);
    assign w_dst_dec  = decode(bus.destination);
    assign w_src_io   = (bus.op == 2'd1 && bus.xfer_type == 2'd3) || (bus.op == 2'd0 && bus.xfer_type == 2'd1);
    assign w_dst_io   = (bus.op == 2'd0 && bus.xfer_type == 2'd3) || (bus.op == 2'd1 && bus.xfer_type == 2'd1);
    assign w_has_rd   = (bus.op == 2'd1) || (bus.xfer_type == 2'd1);
    assign w_has_wr   = (bus.op == 2'd0) || (bus.xfer_type == 2'd1) || (bus.xfer_type == 2'd2);
    assign w_dma      = (bus.xfer_type == 2'd1 || bus.xfer_type == 2'd2) && (bus.count != 6'd0);
    assign w_bad_op   = (bus.op == 2'd0) && (bus.xfer_type == 2'd2);
    assign w_bad_ep   = (w_src_io && !w_src_dec[2]) || (w_dst_io && !w_dst_dec[2]);
    assign w_irq_addr = ADDR_W'(IO_BASE + int'(w_irq_ch) * IO_SPAN);

    // Lowest pending channel wins; round-robin then prefers the lowest channel at or above the pointer.
    always_comb begin
        w_irq_hit = |bus.io_ip;
        w_irq_ch  = 2'd0;
        for (int k = NUM_IO - 1; k >= 0; k--)
            if (bus.io_ip[k]) w_irq_ch = 2'(k);
`ifdef BUS_SEQ_RR_PRIORITY_EN
        for (int k = NUM_IO - 1; k >= 0; k--)
            if (bus.io_ip[k] && k >= int'(r_ptr)) w_irq_ch = 2'(k);
`endif
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_address    <= '0;
            r_dst        <= '0;
            r_firstempty <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_io_rd      <= '0;
            r_io_wr      <= '0;
            r_io_ack     <= '0;
            r_grant      <= 1'b0;
            r_err        <= 1'b0;
            r_two_phase  <= 1'b0;
            r_wr_io      <= 1'b0;
            r_wr_ch      <= 2'd0;
`ifdef BUS_SEQ_RR_PRIORITY_EN
            r_ptr        <= 2'd0;
            r_irq_ch     <= 2'd0;
`endif
        end else begin
            r_address <= '0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_io_rd   <= '0;
            r_io_wr   <= '0;
            r_io_ack  <= '0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (bus.op[1]) begin
                            r_state <= ALU;
                            r_ready <= 1'b0;
                            r_grant <= 1'b1;
                        end else if (w_bad_op) begin
                            r_err <= 1'b1;
                        end else if (w_dma) begin
                            r_state <= DMA;
                            r_ready <= 1'b0;
                            r_grant <= 1'b1;
                        end else if (w_bad_ep) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ready     <= 1'b0;
                            r_dst       <= bus.destination;
                            r_two_phase <= w_has_rd && w_has_wr;
                            r_wr_io     <= w_dst_io;
                            r_wr_ch     <= w_dst_dec[1:0];
                            if (w_has_rd) begin
                                r_state   <= RD;
                                r_address <= bus.source;
                                if (w_src_io) r_io_rd  <= onehot(w_src_dec[1:0]);
                                else          r_mem_rd <= 1'b1;
                            end else begin
                                r_state   <= WR;
                                r_address <= bus.destination;
                                if (w_dst_io) r_io_wr  <= onehot(w_dst_dec[1:0]);
                                else          r_mem_wr <= 1'b1;
                            end
                        end
                    end else if (w_ready && !bus.instr_valid && w_irq_hit) begin
                        r_state      <= IRQ_RD;
                        r_ready      <= 1'b0;
                        r_address    <= w_irq_addr;
                        r_io_rd      <= onehot(w_irq_ch);
                        r_io_ack     <= onehot(w_irq_ch);
                        r_firstempty <= bus.firstempty;
`ifdef BUS_SEQ_RR_PRIORITY_EN
                        r_irq_ch     <= w_irq_ch;
`endif
                    end
                end
                RD: begin
                    if (r_two_phase) begin
                        r_state   <= WR;
                        r_address <= r_dst;
                        if (r_wr_io) r_io_wr  <= onehot(r_wr_ch);
                        else         r_mem_wr <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                WR: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                DMA: begin
                    if (bus.dma_done) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_grant <= 1'b0;
                    end
                end
                ALU: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_grant <= 1'b0;
                end
                IRQ_RD: begin
                    r_state   <= IRQ_WR;
                    r_address <= r_firstempty;
                    r_mem_wr  <= 1'b1;
                end
                IRQ_WR: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
`ifdef BUS_SEQ_RR_PRIORITY_EN
                    r_ptr   <= 2'((int'(r_irq_ch) + 1) % NUM_IO);
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_grant <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.address     = r_address;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_wr      = r_mem_wr;
    assign bus.io_rd       = r_io_rd;
    assign bus.io_wr       = r_io_wr;
    assign bus.io_ack      = r_io_ack;
    assign bus.grant       = r_grant;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: strobe events are scoreboarded by cycle; ready/grant checked inline.
module tb_bus_sequencer;
    localparam int AW  = 8;
    localparam int NIO = 2;
`ifdef BUS_SEQ_RR_PRIORITY_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  addr;
        logic        mr;
        logic        mw;
        logic [1:0]  ir;
        logic [1:0]  iw;
        logic [1:0]  ia;
        logic        e;
    } ev_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   monOn = 1'b0;
    ev_t  expQ[$];
    ev_t  monObs;
    ev_t  monExp;
    int   bDst[4] = '{191, 223, 224, 255};
    logic [1:0] bIw[4] = '{2'b00, 2'b01, 2'b10, 2'b10};

    bus_sequencer_if #(.ADDR_W(AW), .NUM_IO(NIO)) bus ();

    bus_sequencer #(.ADDR_W(AW), .NUM_IO(NIO), .IO_BASE(192), .IO_SPAN(32)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] outBundle();
        return {bus.address, bus.mem_rd, bus.mem_wr, bus.io_rd, bus.io_wr, bus.io_ack, bus.grant, bus.err};
    endfunction

    task automatic expectEv(input int c, input logic [7:0] a, input logic mr, input logic mw,
                            input logic [1:0] ir, input logic [1:0] iw, input logic [1:0] ia, input logic e);
        ev_t ev;
        ev.cyc  = 16'(c);
        ev.addr = a;
        ev.mr   = mr;
        ev.mw   = mw;
        ev.ir   = ir;
        ev.iw   = iw;
        ev.ia   = ia;
        ev.e    = e;
        expQ.push_back(ev);
    endtask

    // Called at a falling edge; the instruction is accepted on the next rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] typ, input logic [5:0] cnt,
                                 input logic [7:0] src, input logic [7:0] dst, output int n);
        bus.op          = op;
        bus.xfer_type   = typ;
        bus.count       = cnt;
        bus.source      = src;
        bus.destination = dst;
        bus.instr_valid = 1'b1;
        n = cyc;
        checkOutput("readyAtOffer", {63'b0, bus.instr_ready}, 64'd1);
    endtask

    task automatic endOffer();
        @(negedge clock);
        bus.instr_valid = 1'b0;
    endtask

    task automatic waitTo(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (monOn && (bus.mem_rd || bus.mem_wr || (|bus.io_rd) || (|bus.io_wr) || (|bus.io_ack) || bus.err)) begin
            monObs.cyc  = 16'(cyc);
            monObs.addr = bus.err ? 8'h00 : bus.address;
            monObs.mr   = bus.mem_rd;
            monObs.mw   = bus.mem_wr;
            monObs.ir   = bus.io_rd;
            monObs.iw   = bus.io_wr;
            monObs.ia   = bus.io_ack;
            monObs.e    = bus.err;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedStrobe", {31'b0, monObs}, 64'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("scoreboard", {31'b0, monObs}, {31'b0, monExp});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int m;
        logic [1:0] ch2;
        bus.instr_valid = 1'b0;
        bus.op          = 2'd0;
        bus.xfer_type   = 2'd0;
        bus.count       = 6'd0;
        bus.source      = 8'd0;
        bus.destination = 8'd0;
        bus.firstempty  = 8'd0;
        bus.busybus     = 1'b0;
        bus.io_ip       = 2'b00;
        bus.dma_done    = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("resetReady", {63'b0, bus.instr_ready}, 64'd0);
        checkOutput("resetOutputs", {46'b0, outBundle()}, 64'd0);
        monOn = 1'b1;
        rst_n = 1'b1;
        #1 checkOutput("readyHeldAtRelease", {63'b0, bus.instr_ready}, 64'd0);
        @(negedge clock);
        checkOutput("readyFirstEdge", {63'b0, bus.instr_ready}, 64'd1);

        // mem -> I/O: read memory then write channel 0
        applyStimulus(2'd1, 2'd1, 6'd0, 8'd10, 8'd200, n);
        expectEv(n + 1, 8'd10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        expectEv(n + 2, 8'd200, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        endOffer();
        waitTo(n + 2);
        checkOutput("readyDuringPhase2", {63'b0, bus.instr_ready}, 64'd0);
        waitTo(n + 3);
        checkOutput("readyAfterTwoPhase", {63'b0, bus.instr_ready}, 64'd1);

        applyStimulus(2'd0, 2'd1, 6'd0, 8'd230, 8'd50, n);
        expectEv(n + 1, 8'd230, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
        expectEv(n + 2, 8'd50, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        endOffer();
        waitTo(n + 3);

        applyStimulus(2'd0, 2'd0, 6'd0, 8'd0, 8'd77, n);
        expectEv(n + 1, 8'd77, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        endOffer();
        waitTo(n + 2);
        checkOutput("readyAfterSingle", {63'b0, bus.instr_ready}, 64'd1);

        applyStimulus(2'd1, 2'd3, 6'd0, 8'd195, 8'd0, n);
        expectEv(n + 1, 8'd195, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        endOffer();
        waitTo(n + 2);

        applyStimulus(2'd1, 2'd2, 6'd0, 8'd3, 8'd4, n);
        expectEv(n + 1, 8'd3, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        expectEv(n + 2, 8'd4, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        endOffer();
        waitTo(n + 3);

        // Channel window edges for register -> I/O writes
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd0, 2'd3, 6'd0, 8'd0, 8'(bDst[i]), n);
            if (bIw[i] == 2'b00) expectEv(n + 1, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
            else                 expectEv(n + 1, 8'(bDst[i]), 1'b0, 1'b0, 2'b00, bIw[i], 2'b00, 1'b0);
            endOffer();
            waitTo(n + 2);
        end

        applyStimulus(2'd0, 2'd3, 6'd0, 8'd0, 8'd100, n);
        expectEv(n + 1, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        endOffer();
        waitTo(n + 2);
        applyStimulus(2'd0, 2'd2, 6'd0, 8'd1, 8'd2, n);
        expectEv(n + 1, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        endOffer();
        waitTo(n + 2);
        applyStimulus(2'd1, 2'd3, 6'd0, 8'd100, 8'd0, n);
        expectEv(n + 1, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        endOffer();
        waitTo(n + 2);

        applyStimulus(2'd2, 2'd0, 6'd0, 8'd0, 8'd0, n);
        endOffer();
        checkOutput("aluGrant", {62'b0, bus.grant, bus.instr_ready}, 64'b10);
        waitTo(n + 2);
        checkOutput("aluDone", {62'b0, bus.grant, bus.instr_ready}, 64'b01);

        // DMA with busybus rising mid-transfer
        applyStimulus(2'd0, 2'd1, 6'd5, 8'd0, 8'd0, n);
        endOffer();
        checkOutput("dmaGrantStart", {63'b0, bus.grant}, 64'd1);
        waitTo(n + 4);
        bus.busybus = 1'b1;
        waitTo(n + 7);
        checkOutput("dmaGrantHeld", {63'b0, bus.grant}, 64'd1);
        bus.busybus  = 1'b0;
        bus.dma_done = 1'b1;
        waitTo(n + 8);
        bus.dma_done = 1'b0;
        checkOutput("dmaDone", {62'b0, bus.grant, bus.instr_ready}, 64'b01);
        bus.busybus = 1'b1;
        #1 checkOutput("readyBusy", {63'b0, bus.instr_ready}, 64'd0);
        bus.busybus = 1'b0;
        @(negedge clock);

        // Interrupt arbitration with both channels pending
        ch2 = RR ? 2'd1 : 2'd0;
        m = cyc;
        bus.firstempty = 8'd60;
        bus.io_ip      = 2'b11;
        expectEv(m + 1, 8'd192, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
        expectEv(m + 2, 8'd60, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        expectEv(m + 4, (ch2 == 2'd1) ? 8'd224 : 8'd192, 1'b0, 1'b0, 2'b01 << ch2, 2'b00, 2'b01 << ch2, 1'b0);
        expectEv(m + 5, 8'd61, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        expectEv(m + 7, 8'd192, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
        expectEv(m + 8, 8'd62, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        waitTo(m + 1);
        bus.firstempty = 8'd61;
        waitTo(m + 4);
        bus.firstempty = 8'd62;
        waitTo(m + 7);
        bus.io_ip = 2'b00;
        waitTo(m + 10);

        // Instruction beats a same-cycle interrupt
        bus.io_ip      = 2'b01;
        bus.firstempty = 8'd90;
        applyStimulus(2'd0, 2'd0, 6'd0, 8'd0, 8'd77, n);
        expectEv(n + 1, 8'd77, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        expectEv(n + 3, 8'd192, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
        expectEv(n + 4, 8'd90, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        endOffer();
        waitTo(n + 3);
        bus.io_ip = 2'b00;
        waitTo(n + 5);
        checkOutput("readyAfterIrq", {63'b0, bus.instr_ready}, 64'd1);

        // Reset during a DMA grant
        applyStimulus(2'd1, 2'd2, 6'd3, 8'd0, 8'd0, n);
        endOffer();
        waitTo(n + 2);
        checkOutput("dmaGrantBeforeReset", {63'b0, bus.grant}, 64'd1);
        rst_n = 1'b0;
        waitTo(n + 3);
        checkOutput("midResetOutputs", {45'b0, bus.instr_ready, outBundle()}, 64'd0);
        rst_n = 1'b1;
        waitTo(n + 4);
        checkOutput("readyAfterMidReset", {62'b0, bus.grant, bus.instr_ready}, 64'b01);

        waitTo(cyc + 2);
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 8, address width; NUM_IO, 2, I/O channel count (1..4); IO_BASE, 192, first I/O address; IO_SPAN, 32, addresses per channel; IO_BASE+NUM_IO*IO_SPAN SHALL be <= 2^ADDR_W.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock, all logic on posedge.
- rst_n, in, 1: synchronous active-low reset.
- instr_valid, in, 1: instruction offered.
- instr_ready, out, 1: sequencer accepts.
- op, in, 2: opcode.
- type, in, 2: transfer type.
- count, in, 6: word count; 0 = single word.
- source, in, ADDR_W: read address.
- destination, in, ADDR_W: write address.
- firstempty, in, ADDR_W: interrupt store address.
- busybus, in, 1: bus owned elsewhere.
- io_ip, in, NUM_IO: interrupt requests.
- dma_done, in, 1: DMA finished.
- address, out, ADDR_W: bus address.
- mem_rd, out, 1: memory read.
- mem_wr, out, 1: memory write.
- io_rd, out, NUM_IO: one-hot I/O read.
- io_wr, out, NUM_IO: one-hot I/O write.
- io_ack, out, NUM_IO: one-hot interrupt acknowledge.
- grant, out, 1: bus granted to DMA.
- err, out, 1: one-cycle illegal/unmapped pulse.

Function
REQ-003 FSM states SHALL be IDLE, RD, WR, DMA, ALU, IRQ_RD, IRQ_WR; all outputs registered; undriven strobes SHALL be 0, never X.
REQ-004 instr_ready SHALL equal (state==IDLE && !busybus); acceptance = instr_valid && instr_ready; source/destination/count/op/type captured at acceptance.
REQ-005 Channel decode: addr in [IO_BASE+k*IO_SPAN, IO_BASE+(k+1)*IO_SPAN-1] maps to channel k < NUM_IO; any other address is memory.
REQ-006 Routing (op,type): (0,3) reg->I/O: WR only; (1,3) I/O->reg: RD only; (0,0) reg->mem: WR only; (1,0) mem->reg: RD only; (1,1,count=0) mem->I/O: RD,WR; (0,1,count=0) I/O->mem: RD,WR; (1,2,count=0) mem->mem: RD,WR.
REQ-007 RD phase: address=source, mem_rd or io_rd[k] high for exactly one cycle; WR phase: address=destination, mem_wr or io_wr[k] high for exactly one cycle.
REQ-008 Latency: accept cycle N -> first phase N+1 -> second phase (if any) N+2; instr_ready SHALL reassert the cycle after the last phase.
REQ-009 type 1 or 2 with count!=0: enter DMA, grant=1 from N+1 until the cycle dma_done is sampled high, then IDLE with grant=0.
REQ-010 op 2 or 3 (ALU): enter ALU for one cycle with grant=1 and no strobes, then IDLE.
REQ-011 op=0,type=2, or an I/O-typed endpoint address that decodes to no channel: err=1 for one cycle at N+1, no strobes, return to IDLE.
REQ-012 Interrupts SHALL be serviced only in IDLE with !busybus && !instr_valid && |io_ip; instructions win same-cycle conflicts.
REQ-013 Interrupt service: IRQ_RD asserts io_rd[k], io_ack[k], address=IO_BASE+k*IO_SPAN; firstempty captured on IRQ_RD entry; IRQ_WR asserts mem_wr with address=captured firstempty; then IDLE.
REQ-014 busybus rising outside IDLE SHALL NOT abort an operation in progress.

Reset
REQ-015 rst_n=0 at a posedge SHALL force IDLE, all outputs 0, instr_ready=0, and the priority pointer to 0, including mid-operation (grant drops the same edge).
REQ-016 instr_ready SHALL first assert on the edge after rst_n returns high.

Configuration
REQ-017 Macro BUS_SEQ_RR_PRIORITY_EN: defined -> round-robin interrupt arbitration, pointer moves to served channel+1 (mod NUM_IO) after each IRQ_WR; undefined -> fixed priority, lowest index wins, no pointer state.

Verification
REQ-018 (1,1,count=0), source=10, destination=200 -> N+1 mem_rd, address=10; N+2 io_wr=01, address=200; ready at N+3.
REQ-019 (0,1,count=5) -> grant=1 from N+1; dma_done pulse at N+7 -> grant=0 and ready at N+8.
REQ-020 io_ip=11 held, no instructions, RR defined -> services ch0, then ch1, then ch0; undefined -> ch0 every time.
REQ-021 (0,3), destination=100 -> err=1 at N+1, no strobes; (0,2) -> err=1.
REQ-022 rst_n=0 during DMA grant -> next edge all outputs 0, state IDLE; instr_valid with io_ip=01 in IDLE -> instruction served first.
